pipe_front_regs: RTL and testbench
==================================

# pipe_front_regs

Front-end pipeline state for the 5-stage RV32 core: PC register, IF/ID register and ID/EX register, all driven by the stall/flush controls from the hazard unit. It applies stallF/stallD/flushD/flushE and the branch redirect to the fetch and decode boundaries. It also keeps saturating stall and flush event counters for performance debug. It sits between instruction memory / decode and the execute stage.

## Interface
Parameters:
- XLEN, 32, datapath width
- CTRL_W, 12, width of packed decode control bundle (bit 0 = reg_wr, bits 2:1 = sel_wb)
- RESET_PC, 32'h0000_0000, fetch address after reset
- CNT_W, 32, event counter width

Ports:
- clk  in  1  clock (all state on rising edge)
- rst_n  in  1  asynchronous active-low reset
- stallF, stallD, flushD, flushE  in  1 each  hazard controls
- br_en_E  in  1  taken branch/jump resolved in E
- pc_target_E  in  XLEN  redirect address
- instr_F  in  32  instruction at pc_F (combinational imem read)
- pc_F  out  XLEN  current fetch address
- instr_D, pc_D, pc_plus4_D  out  32/XLEN/XLEN  IF/ID contents
- valid_D  out  1  IF/ID holds a real instruction
- rs1_D, rs2_D, rd_D  in  5 each; imm_D, rd1_D, rd2_D  in  XLEN each; ctrl_D  in  CTRL_W
- rs1_E, rs2_E, rd_E  out  5 each; imm_E, rd1_E, rd2_E, pc_E, pc_plus4_E  out  XLEN; ctrl_E  out  CTRL_W; valid_E  out  1
- clr_cnt  in  1  synchronous counter clear
- stall_cnt, flush_cnt  out  CNT_W each

## Operation
- PC: br_en_E=1 -> pc_F <= pc_target_E (overrides stallF); else stallF=1 -> hold; else pc_F <= pc_F + 4 (mod 2^XLEN, wraps).
- IF/ID priority: flushD > stallD > capture. Flush loads bubble: instr_D=32'h0000_0013 (NOP), pc_D=0, pc_plus4_D=0, valid_D=0. Stall holds all fields. Capture: instr_D<=instr_F, pc_D<=pc_F, pc_plus4_D<=pc_F+4, valid_D<=1.
- ID/EX: no stall input. flushE=1 -> bubble: ctrl_E=0, rs1_E=rs2_E=rd_E=0, imm_E=rd1_E=rd2_E=pc_E=pc_plus4_E=0, valid_E=0. Otherwise capture all *_D inputs, pc_D, pc_plus4_D, valid_E<=valid_D.
- Bubble must have reg_wr=0 and rd=0 so no forwarding or writeback is triggered downstream.
- stall_cnt: +1 each cycle stallD=1 and flushD=0. flush_cnt: +1 each cycle flushD=1. Both saturate at all-ones. clr_cnt=1 zeroes both that cycle, overriding increment.
- Reset (asynchronous, any time incl. mid-stall): pc_F=RESET_PC; IF/ID and ID/EX in bubble state; counters 0. First release edge captures instr at RESET_PC into IF/ID.

## Timing
- All outputs registered; one-cycle latency per boundary.
- Redirect: br_en_E in cycle n -> pc_F=pc_target_E in n+1; flushD/flushE in n bubble D and E in n+1.
- Load-use stall (stallF=stallD=flushE=1 in n): pc_F, IF/ID unchanged in n+1; E holds bubble in n+1; held instruction enters E in n+2 once controls drop.
- stallD and flushD both high: flush wins, stall_cnt not incremented.
- Simultaneous br_en_E and stallF: PC redirects.

## Test plan
- Reset: hold rst_n=0, then release; RESET_PC=0x100 -> pc_F=0x100, valid_D=0, valid_E=0, ctrl_E=0; after 2 edges pc_F=0x108, pc_D=0x104, valid_D=1.
- Straight-line: no hazards for 6 cycles -> pc_F advances by 4 each cycle; pc_E lags pc_F by 8; ID/EX fields equal previous-cycle *_D inputs.
- Load-use stall: one cycle stallF=stallD=flushE=1 with pc_D=0x10 -> pc_D stays 0x10, E bubble (rd_E=0, valid_E=0), next cycle pc_E=0x10; stall_cnt=1.
- Branch: br_en_E=1, pc_target_E=0x200, flushD=flushE=1 -> next cycle pc_F=0x200, instr_D=0x00000013, valid_D=0, valid_E=0; flush_cnt=1.
- Conflicts: stallD=flushD=1 -> IF/ID bubble, stall_cnt unchanged; br_en_E=stallF=1 -> pc_F=pc_target_E; pc_F=0xFFFF_FFFC advances to 0.
- Counters/reset: CNT_W=4, 20 stall cycles -> stall_cnt=15; clr_cnt with stallD=1 -> 0; assert rst_n=0 mid-stall -> all state to reset values without clock edge.

Source files
------------

// File: rtl/pipe_front_regs.sv
// Front-end pipeline state of the RV32 core: fetch PC, IF/ID and ID/EX registers
// under hazard-unit stall/flush control, plus saturating stall/flush event counters.
module pipe_front_regs #(
  parameter int unsigned          XLEN     = 32'd32,
  parameter int unsigned          CTRL_W   = 32'd12,
  parameter logic [XLEN-1:0]      RESET_PC = XLEN'(32'h0000_0000),
  parameter int unsigned          CNT_W    = 32'd32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              flushE,
  input  logic              br_en_E,
  input  logic [XLEN-1:0]   pc_target_E,
  input  logic [31:0]       instr_F,
  output logic [XLEN-1:0]   pc_F,
  output logic [31:0]       instr_D,
  output logic [XLEN-1:0]   pc_D,
  output logic [XLEN-1:0]   pc_plus4_D,
  output logic              valid_D,
  input  logic [4:0]        rs1_D,
  input  logic [4:0]        rs2_D,
  input  logic [4:0]        rd_D,
  input  logic [XLEN-1:0]   imm_D,
  input  logic [XLEN-1:0]   rd1_D,
  input  logic [XLEN-1:0]   rd2_D,
  input  logic [CTRL_W-1:0] ctrl_D,
  output logic [4:0]        rs1_E,
  output logic [4:0]        rs2_E,
  output logic [4:0]        rd_E,
  output logic [XLEN-1:0]   imm_E,
  output logic [XLEN-1:0]   rd1_E,
  output logic [XLEN-1:0]   rd2_E,
  output logic [XLEN-1:0]   pc_E,
  output logic [XLEN-1:0]   pc_plus4_E,
  output logic [CTRL_W-1:0] ctrl_E,
  output logic              valid_E,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(32'd4);
  localparam logic [XLEN-1:0]  XZERO     = {XLEN{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Saturating increment: sticks at all-ones so a long stall never wraps to a small count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (val == CNT_MAX) begin
      res = val;
    end else begin
      res = val + CNT_W'(1'b1);
    end
    return res;
  endfunction

  logic [XLEN-1:0]   pc_f_r, pc_next_s, pc_f_plus4_s;
  logic [31:0]       instr_d_r;
  logic [XLEN-1:0]   pc_d_r, pc_plus4_d_r;
  logic              valid_d_r;
  logic [4:0]        rs1_e_r, rs2_e_r, rd_e_r;
  logic [XLEN-1:0]   imm_e_r, rd1_e_r, rd2_e_r, pc_e_r, pc_plus4_e_r;
  logic [CTRL_W-1:0] ctrl_e_r;
  logic              valid_e_r;
  logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
  logic              stall_evt_s;

  assign pc_f_plus4_s = pc_f_r + PC_STEP;
  // A flushed decode slot is not counted as a stall even when stallD is also high.
  assign stall_evt_s  = stallD & ~flushD;

  // Next fetch address: a resolved branch beats a fetch stall.
  always_comb begin
    pc_next_s = pc_f_plus4_s;
    if (br_en_E) begin
      pc_next_s = pc_target_E;
    end else if (stallF) begin
      pc_next_s = pc_f_r;
    end else begin
      pc_next_s = pc_f_plus4_s;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_r <= RESET_PC;
    end else begin
      pc_f_r <= pc_next_s;
    end
  end

  // IF/ID boundary: flush loads a NOP bubble, stall holds, otherwise capture fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d_r    <= NOP_INSTR;
      pc_d_r       <= XZERO;
      pc_plus4_d_r <= XZERO;
      valid_d_r    <= 1'b0;
    end else if (flushD) begin
      instr_d_r    <= NOP_INSTR;
      pc_d_r       <= XZERO;
      pc_plus4_d_r <= XZERO;
      valid_d_r    <= 1'b0;
    end else if (stallD) begin
      instr_d_r    <= instr_d_r;
      pc_d_r       <= pc_d_r;
      pc_plus4_d_r <= pc_plus4_d_r;
      valid_d_r    <= valid_d_r;
    end else begin
      instr_d_r    <= instr_F;
      pc_d_r       <= pc_f_r;
      pc_plus4_d_r <= pc_f_plus4_s;
      valid_d_r    <= 1'b1;
    end
  end

  // ID/EX boundary: bubble has ctrl=0 (reg_wr=0) and rd=0 so nothing forwards or writes back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_e_r      <= 5'd0;
      rs2_e_r      <= 5'd0;
      rd_e_r       <= 5'd0;
      imm_e_r      <= XZERO;
      rd1_e_r      <= XZERO;
      rd2_e_r      <= XZERO;
      pc_e_r       <= XZERO;
      pc_plus4_e_r <= XZERO;
      ctrl_e_r     <= {CTRL_W{1'b0}};
      valid_e_r    <= 1'b0;
    end else if (flushE) begin
      rs1_e_r      <= 5'd0;
      rs2_e_r      <= 5'd0;
      rd_e_r       <= 5'd0;
      imm_e_r      <= XZERO;
      rd1_e_r      <= XZERO;
      rd2_e_r      <= XZERO;
      pc_e_r       <= XZERO;
      pc_plus4_e_r <= XZERO;
      ctrl_e_r     <= {CTRL_W{1'b0}};
      valid_e_r    <= 1'b0;
    end else begin
      rs1_e_r      <= rs1_D;
      rs2_e_r      <= rs2_D;
      rd_e_r       <= rd_D;
      imm_e_r      <= imm_D;
      rd1_e_r      <= rd1_D;
      rd2_e_r      <= rd2_D;
      pc_e_r       <= pc_d_r;
      pc_plus4_e_r <= pc_plus4_d_r;
      ctrl_e_r     <= ctrl_D;
      valid_e_r    <= valid_d_r;
    end
  end

  // Performance counters: clear overrides increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r <= stall_evt_s ? sat_inc(stall_cnt_r) : stall_cnt_r;
      flush_cnt_r <= flushD ? sat_inc(flush_cnt_r) : flush_cnt_r;
    end
  end

  assign pc_F       = pc_f_r;
  assign instr_D    = instr_d_r;
  assign pc_D       = pc_d_r;
  assign pc_plus4_D = pc_plus4_d_r;
  assign valid_D    = valid_d_r;
  assign rs1_E      = rs1_e_r;
  assign rs2_E      = rs2_e_r;
  assign rd_E       = rd_e_r;
  assign imm_E      = imm_e_r;
  assign rd1_E      = rd1_e_r;
  assign rd2_E      = rd2_e_r;
  assign pc_E       = pc_e_r;
  assign pc_plus4_E = pc_plus4_e_r;
  assign ctrl_E     = ctrl_e_r;
  assign valid_E    = valid_e_r;
  assign stall_cnt  = stall_cnt_r;
  assign flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Bench for pipe_front_regs (RESET_PC=0x100, CNT_W=4): a reference model pushes the
// expected post-edge state into a scoreboard queue; scenario tasks add targeted checks.
module tb_pipe_front_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallF, stallD, flushD, flushE, br_en_E, clr_cnt;
  logic [31:0] pc_target_E, instr_F, pc_F, instr_D, pc_D, pc_plus4_D;
  logic        valid_D, valid_E;
  logic [4:0]  rs1_D, rs2_D, rd_D, rs1_E, rs2_E, rd_E;
  logic [31:0] imm_D, rd1_D, rd2_D, imm_E, rd1_E, rd2_E, pc_E, pc_plus4_E;
  logic [11:0] ctrl_D, ctrl_E;
  logic [3:0]  stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc_f, instr_d, pc_d, pc4_d;
    logic        vd;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, rd1, rd2, pc_e, pc4_e;
    logic [11:0] ctrl;
    logic        ve;
    logic [3:0]  sc, fc;
  } st_t;

  st_t m;
  st_t sb[$];

  function automatic logic [31:0] imem(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0003;
  endfunction

  assign instr_F = imem(pc_F);

  always #5 clk = ~clk;

  pipe_front_regs #(
    .XLEN(32), .CTRL_W(12), .RESET_PC(32'h0000_0100), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .br_en_E(br_en_E), .pc_target_E(pc_target_E), .instr_F(instr_F),
    .pc_F(pc_F), .instr_D(instr_D), .pc_D(pc_D), .pc_plus4_D(pc_plus4_D), .valid_D(valid_D),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .imm_D(imm_D), .rd1_D(rd1_D), .rd2_D(rd2_D),
    .ctrl_D(ctrl_D),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .imm_E(imm_E), .rd1_E(rd1_E), .rd2_E(rd2_E),
    .pc_E(pc_E), .pc_plus4_E(pc_plus4_E), .ctrl_E(ctrl_E), .valid_E(valid_E),
    .clr_cnt(clr_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic model_reset();
    m = '0;
    m.pc_f    = 32'h0000_0100;
    m.instr_d = 32'h0000_0013;
    sb.delete();
  endtask

  // Drive one cycle, push the model's expected state at the edge, compare at the following negedge.
  task automatic drive(input logic sF, input logic sD, input logic fD, input logic fE,
                       input logic br, input logic [31:0] tgt, input logic clr);
    st_t n, e;
    stallF = sF; stallD = sD; flushD = fD; flushE = fE;
    br_en_E = br; pc_target_E = tgt; clr_cnt = clr;
    rs1_D = 5'($urandom); rs2_D = 5'($urandom); rd_D = 5'($urandom);
    imm_D = $urandom; rd1_D = $urandom; rd2_D = $urandom; ctrl_D = 12'($urandom);
    n = m;
    n.pc_f = br ? tgt : (sF ? m.pc_f : m.pc_f + 32'd4);
    if (fD) begin
      n.instr_d = 32'h0000_0013; n.pc_d = 32'd0; n.pc4_d = 32'd0; n.vd = 1'b0;
    end else if (!sD) begin
      n.instr_d = imem(m.pc_f); n.pc_d = m.pc_f; n.pc4_d = m.pc_f + 32'd4; n.vd = 1'b1;
    end
    if (fE) begin
      n.rs1 = 5'd0; n.rs2 = 5'd0; n.rd = 5'd0; n.imm = 32'd0; n.rd1 = 32'd0; n.rd2 = 32'd0;
      n.pc_e = 32'd0; n.pc4_e = 32'd0; n.ctrl = 12'd0; n.ve = 1'b0;
    end else begin
      n.rs1 = rs1_D; n.rs2 = rs2_D; n.rd = rd_D; n.imm = imm_D; n.rd1 = rd1_D; n.rd2 = rd2_D;
      n.pc_e = m.pc_d; n.pc4_e = m.pc4_d; n.ctrl = ctrl_D; n.ve = m.vd;
    end
    if (clr) begin
      n.sc = 4'd0; n.fc = 4'd0;
    end else begin
      if (sD && !fD && m.sc != 4'hF) n.sc = m.sc + 4'd1;
      if (fD && m.fc != 4'hF) n.fc = m.fc + 4'd1;
    end
    @(posedge clk);
    sb.push_back(n);
    m = n;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (pc_F !== e.pc_f) begin
      errors++; $display("FAIL sb_pc: got %h expected %h", pc_F, e.pc_f);
    end
    checks++;
    if ({instr_D, pc_D, pc_plus4_D, valid_D} !== {e.instr_d, e.pc_d, e.pc4_d, e.vd}) begin
      errors++;
      $display("FAIL sb_ifid: got %h/%h/%h/%b expected %h/%h/%h/%b", instr_D, pc_D, pc_plus4_D,
               valid_D, e.instr_d, e.pc_d, e.pc4_d, e.vd);
    end
    checks++;
    if ({rs1_E, rs2_E, rd_E, imm_E, rd1_E, rd2_E, pc_E, pc_plus4_E, ctrl_E, valid_E} !==
        {e.rs1, e.rs2, e.rd, e.imm, e.rd1, e.rd2, e.pc_e, e.pc4_e, e.ctrl, e.ve}) begin
      errors++;
      $display("FAIL sb_idex: got rd=%h pc=%h ctrl=%h v=%b expected rd=%h pc=%h ctrl=%h v=%b",
               rd_E, pc_E, ctrl_E, valid_E, e.rd, e.pc_e, e.ctrl, e.ve);
    end
    checks++;
    if ({stall_cnt, flush_cnt} !== {e.sc, e.fc}) begin
      errors++;
      $display("FAIL sb_cnt: got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt, e.sc, e.fc);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({pc_F, valid_D, valid_E, ctrl_E} !== {32'h0000_0100, 1'b0, 1'b0, 12'd0}) begin
      errors++;
      $display("FAIL reset_state: got pc=%h vD=%b vE=%b ctrl=%h expected pc=00000100 vD=0 vE=0 ctrl=000",
               pc_F, valid_D, valid_E, ctrl_E);
    end
    rst_n = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    checks++;
    if ({pc_F, pc_D, valid_D} !== {32'h0000_0108, 32'h0000_0104, 1'b1}) begin
      errors++;
      $display("FAIL reset_release: got pc_F=%h pc_D=%h vD=%b expected 00000108 00000104 1",
               pc_F, pc_D, valid_D);
    end
  endtask

  task automatic drive_idle_inputs();
    stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; flushE = 1'b0; br_en_E = 1'b0;
    pc_target_E = 32'd0; clr_cnt = 1'b0;
    rs1_D = 5'd0; rs2_D = 5'd0; rd_D = 5'd0; imm_D = 32'd0; rd1_D = 32'd0; rd2_D = 32'd0;
    ctrl_D = 12'd0;
  endtask

  task automatic test_straight();
    logic [31:0] prev;
    prev = pc_F;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      checks++;
      if (pc_F !== prev + 32'd4 || pc_E !== pc_F - 32'd8) begin
        errors++;
        $display("FAIL straight_pc: got pc_F=%h pc_E=%h expected pc_F=%h pc_E=%h",
                 pc_F, pc_E, prev + 32'd4, prev - 32'd4);
      end
      prev = pc_F;
    end
  endtask

  task automatic test_load_use();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    checks++;
    if ({pc_D, rd_E, valid_E, stall_cnt} !== {32'h0000_0010, 5'd0, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL load_use_stall: got pc_D=%h rd_E=%0d vE=%b stall_cnt=%0d expected 00000010 0 0 1",
               pc_D, rd_E, valid_E, stall_cnt);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    checks++;
    if ({pc_E, valid_E} !== {32'h0000_0010, 1'b1}) begin
      errors++;
      $display("FAIL load_use_release: got pc_E=%h vE=%b expected 00000010 1", pc_E, valid_E);
    end
  endtask

  task automatic test_branch();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    checks++;
    if ({pc_F, instr_D, valid_D, valid_E, flush_cnt} !==
        {32'h0000_0200, 32'h0000_0013, 1'b0, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL branch: got pc_F=%h instr_D=%h vD=%b vE=%b flush_cnt=%0d expected 00000200 00000013 0 0 1",
               pc_F, instr_D, valid_D, valid_E, flush_cnt);
    end
  endtask

  task automatic test_conflicts();
    logic [3:0] sc;
    sc = stall_cnt;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    checks++;
    if ({valid_D, instr_D, stall_cnt} !== {1'b0, 32'h0000_0013, sc}) begin
      errors++;
      $display("FAIL stall_flush: got vD=%b instr_D=%h stall_cnt=%0d expected 0 00000013 %0d",
               valid_D, instr_D, stall_cnt, sc);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0);
    checks++;
    if (pc_F !== 32'h0000_0300) begin
      errors++; $display("FAIL br_over_stall: got %h expected 00000300", pc_F);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    checks++;
    if ({pc_F, pc_D, pc_plus4_D} !== {32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000}) begin
      errors++;
      $display("FAIL pc_wrap: got pc_F=%h pc_D=%h pc4_D=%h expected 00000000 fffffffc 00000000",
               pc_F, pc_D, pc_plus4_D);
    end
  endtask

  task automatic test_counters();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++; $display("FAIL stall_saturate: got %0d expected 15", stall_cnt);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++; $display("FAIL clr_cnt: got %0d expected 0", stall_cnt);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    // Asynchronous reset while stalled: outputs must drop without waiting for an edge.
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pc_F, instr_D, valid_D, valid_E, rd_E, ctrl_E, stall_cnt} !==
        {32'h0000_0100, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 12'd0, 4'd0}) begin
      errors++;
      $display("FAIL async_reset: got pc_F=%h instr_D=%h vD=%b vE=%b rd_E=%0d ctrl_E=%h stall_cnt=%0d",
               pc_F, instr_D, valid_D, valid_E, rd_E, ctrl_E, stall_cnt);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    checks++;
    if ({pc_F, pc_D, valid_D} !== {32'h0000_0104, 32'h0000_0100, 1'b1}) begin
      errors++;
      $display("FAIL reset_recover: got pc_F=%h pc_D=%h vD=%b expected 00000104 00000100 1",
               pc_F, pc_D, valid_D);
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_load_use();
    test_branch();
    test_conflicts();
    test_counters();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
